cg_palette_mapper: RTL and testbench

// - Parametrised successor to the fixed 16-entry Colour Genie palette lookup in the emu top.
// - Maps a per-pixel colour index to RGB through a register palette. The palette is writable at run time from the hps_io download stream.
// - Delays sync/blank/DE to stay aligned with the RGB output, and forces a background index when the pixel is off.
// - Sits between the eg2000 core video outputs and video_mixer.

---
 rtl/cg_palette_mapper.sv | 128 ++++++++++++
 tb/tb_cg_palette_mapper.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cg_palette_mapper.sv
// cg_palette_mapper: colour index to RGB via a palette, with 2-strobe aligned sync/blank/DE.
// Define CG_PAL_LOADER_EN to make the palette writable from the ioctl download stream.
module cg_palette_mapper #(
  parameter int IDX_W = 4,
  parameter int CH_W = 8,
  parameter logic [7:0] LD_IDX = 8'd3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic             pixel,
  input  logic [IDX_W-1:0] color,
  input  logic [IDX_W-1:0] bg_idx,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             hb_in,
  input  logic             vb_in,
  input  logic             de_in,
  output logic [CH_W-1:0]  r_out,
  output logic [CH_W-1:0]  g_out,
  output logic [CH_W-1:0]  b_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             hb_out,
  output logic             vb_out,
  output logic             de_out,
  input  logic             ld_go,
  input  logic [7:0]       ld_index,
  input  logic             ld_wr,
  input  logic [7:0]       ld_data,
  output logic             ld_done
);
  localparam int N = 2 ** IDX_W;
  function automatic logic [3*CH_W-1:0] def_rgb(input int i);
    logic [23:0] c;
    case (i % 16)
      0: c = 24'h5E5E5E;
      1: c = 24'h7CFFEA;
      2: c = 24'hCB265E;
      3: c = 24'hEAEAEA;
      4: c = 24'hFFF23D;
      5: c = 24'hABFF4A;
      6: c = 24'hEB6F2B;
      7: c = 24'hEAFF27;
      8: c = 24'h2F53FF;
      9: c = 24'hBCDFFF;
      10: c = 24'hC74EFF;
      11: c = 24'h8A67FF;
      12: c = 24'h8C8C8C;
      13: c = 24'h1FC48C;
      14: c = 24'h9820FF;
      default: c = 24'hFFFFFF;
    endcase
    return {c[23 -: CH_W], c[15 -: CH_W], c[7 -: CH_W]};
  endfunction
  logic [3*CH_W-1:0] pal [N];
  logic [IDX_W-1:0] idx_q;
  logic [4:0] sync_q, sync_o;
  logic [3*CH_W-1:0] rgb;
  // sync_q/sync_o bit order: {hs, vs, hb, vb, de}
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      idx_q <= '0;
      sync_q <= '0;
      sync_o <= '0;
      rgb <= '0;
    end else if (ce_pix) begin
      idx_q <= pixel ? color : bg_idx;
      sync_q <= {hs_in, vs_in, hb_in, vb_in, de_in};
      rgb <= (sync_q[2] | sync_q[1]) ? '0 : pal[idx_q];
      sync_o <= sync_q;
    end
  assign {r_out, g_out, b_out} = rgb;
  assign {hs_out, vs_out, hb_out, vb_out, de_out} = sync_o;
`ifdef CG_PAL_LOADER_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic go_q, sel, wr_ok;
  logic [1:0] byte_cnt;
  logic [IDX_W:0] entry_cnt;
  logic [CH_W-1:0] r_b, g_b;
  logic unused_ld;
  assign unused_ld = &{1'b0, ld_data};
  assign sel = ld_index == LD_IDX;
  assign wr_ok = state == LOAD && ld_wr && ld_go && sel && entry_cnt < (IDX_W+1)'(N);
  assign ld_done = state == DONE && entry_cnt != '0;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (ld_go && !go_q && sel) ? LOAD : IDLE;
    else if (state == LOAD) state_nx = (!ld_go && go_q) ? DONE : LOAD;
    else state_nx = IDLE;
  end
  // Bytes stage in r_b/g_b so a palette entry only ever changes as a whole.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      go_q <= 1'b0;
      byte_cnt <= '0;
      entry_cnt <= '0;
      r_b <= '0;
      g_b <= '0;
      for (int i = 0; i < N; i++) pal[i] <= def_rgb(i);
    end else begin
      go_q <= ld_go;
      if (state == IDLE && state_nx == LOAD) begin
        byte_cnt <= '0;
        entry_cnt <= '0;
      end else if (wr_ok) begin
        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
        if (byte_cnt == 2'd0) r_b <= ld_data[7 -: CH_W];
        if (byte_cnt == 2'd1) g_b <= ld_data[7 -: CH_W];
        if (byte_cnt == 2'd2) begin
          pal[entry_cnt[IDX_W-1:0]] <= {r_b, g_b, ld_data[7 -: CH_W]};
          entry_cnt <= entry_cnt + 1'b1;
        end
      end
    end
`else
  logic unused_ld;
  assign unused_ld = &{1'b0, ld_go, ld_index, ld_wr, ld_data};
  assign ld_done = 1'b0;
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign pal[k] = def_rgb(k);
  end
`endif
endmodule

// File: tb/tb_cg_palette_mapper.sv
// tb_cg_palette_mapper: directed checks of pipeline, blanking, loader and reset behaviour.
module tb_cg_palette_mapper;
`ifdef CG_PAL_LOADER_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif
  logic clk_sys = 0, reset_n = 0, ce_pix = 0, pixel = 0;
  logic [3:0] color = 0, bg_idx = 0;
  logic hs_in = 0, vs_in = 0, hb_in = 0, vb_in = 0, de_in = 0;
  logic [7:0] r_out, g_out, b_out;
  logic hs_out, vs_out, hb_out, vb_out, de_out;
  logic ld_go = 0, ld_wr = 0, ld_done;
  logic [7:0] ld_index = 0, ld_data = 0;
  int tests = 0, failed = 0, done_cnt = 0;
  cg_palette_mapper dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .pixel(pixel),
    .color(color), .bg_idx(bg_idx), .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in),
    .vb_in(vb_in), .de_in(de_in), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out), .de_out(de_out),
    .ld_go(ld_go), .ld_index(ld_index), .ld_wr(ld_wr), .ld_data(ld_data), .ld_done(ld_done)
  );
  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) if (ld_done) done_cnt++;
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rgb();
    return {8'h0, r_out, g_out, b_out};
  endfunction
  function automatic logic [31:0] syn();
    return {27'h0, hs_out, vs_out, hb_out, vb_out, de_out};
  endfunction
  task automatic strobe();
    @(negedge clk_sys);
    ce_pix = 1;
    @(negedge clk_sys);
    ce_pix = 0;
  endtask
  task automatic show(input logic [3:0] idx);
    pixel = 1; color = idx; hs_in = 0; vs_in = 0; hb_in = 0; vb_in = 0; de_in = 1;
    strobe();
    strobe();
  endtask
  task automatic ld_byte(input logic [7:0] d);
    @(negedge clk_sys);
    ld_wr = 1; ld_data = d;
    @(negedge clk_sys);
    ld_wr = 0;
  endtask
  task automatic dl(input logic [7:0] idx, input int n, input logic [7:0] base, input logic [7:0] step);
    done_cnt = 0;
    ld_index = idx;
    @(negedge clk_sys);
    ld_go = 1;
    for (int k = 0; k < n; k++) ld_byte(base + step * 8'(k));
    @(negedge clk_sys);
    ld_go = 0;
    repeat (4) @(negedge clk_sys);
  endtask
  initial begin
    hs_in = 1; de_in = 1; pixel = 1; color = 4'd7;
    repeat (3) @(negedge clk_sys);
    check("reset_rgb", rgb(), 32'h0);
    check("reset_sync", syn(), 32'h0);
    check("reset_done", {31'h0, ld_done}, 32'h0);
    reset_n = 1;
    pixel = 1; color = 4'd2; hs_in = 1; de_in = 1;
    strobe();
    check("lat1_rgb", rgb(), 32'h5E5E5E);
    check("lat1_sync", syn(), 32'h0);
    strobe();
    check("lat2_rgb", rgb(), 32'hCB265E);
    check("lat2_sync", syn(), 32'b10001);
    color = 4'd9; hs_in = 0;
    repeat (3) @(negedge clk_sys);
    check("hold_rgb", rgb(), 32'hCB265E);
    check("hold_sync", syn(), 32'b10001);
    pixel = 0; bg_idx = 4'd15; color = 4'd2;
    strobe();
    check("bg1_rgb", rgb(), 32'hCB265E);
    strobe();
    check("bg2_rgb", rgb(), 32'hFFFFFF);
    check("bg2_sync", syn(), 32'b00001);
    hb_in = 1; de_in = 0;
    strobe();
    check("hb1_rgb", rgb(), 32'hFFFFFF);
    check("hb1_sync", syn(), 32'b00001);
    strobe();
    check("hb2_rgb", rgb(), 32'h0);
    check("hb2_sync", syn(), 32'b00100);
    hb_in = 0; vb_in = 1; vs_in = 1; pixel = 1; color = 4'd8;
    strobe();
    strobe();
    check("vb_rgb", rgb(), 32'h0);
    check("vb_sync", syn(), 32'b01010);
    show(4'd9);
    check("idx9_rgb", rgb(), 32'hBCDFFF);
    check("idx9_sync", syn(), 32'b00001);
    dl(8'd3, 5, 8'h11, 8'h11);
    check("dl5_done", done_cnt, LD ? 1 : 0);
    show(4'd0);
    check("dl5_e0", rgb(), LD ? 32'h112233 : 32'h5E5E5E);
    show(4'd1);
    check("dl5_e1", rgb(), 32'h7CFFEA);
    dl(8'd1, 3, 8'hAA, 8'h11);
    check("wrongidx_done", done_cnt, 0);
    show(4'd0);
    check("wrongidx_e0", rgb(), LD ? 32'h112233 : 32'h5E5E5E);
    dl(8'd3, 54, 8'h00, 8'h01);
    check("full_done", done_cnt, LD ? 1 : 0);
    show(4'd0);
    check("full_e0", rgb(), LD ? 32'h000102 : 32'h5E5E5E);
    show(4'd15);
    check("full_e15", rgb(), LD ? 32'h2D2E2F : 32'hFFFFFF);
    show(4'd5);
    check("full_e5", rgb(), LD ? 32'h0F1011 : 32'hABFF4A);
    done_cnt = 0;
    ld_index = 8'd3;
    @(negedge clk_sys);
    ld_go = 1;
    for (int k = 0; k < 17; k++) ld_byte(8'h80 + 8'(k));
    @(negedge clk_sys);
    ld_wr = 1; ld_data = 8'h91; ce_pix = 1;
    @(negedge clk_sys);
    ld_wr = 0; ce_pix = 0;
    check("commit_old", rgb(), LD ? 32'h0F1011 : 32'hABFF4A);
    strobe();
    check("commit_new", rgb(), LD ? 32'h8F9091 : 32'hABFF4A);
    ld_go = 0;
    repeat (4) @(negedge clk_sys);
    check("commit_done", done_cnt, LD ? 1 : 0);
    ld_index = 8'd3;
    @(negedge clk_sys);
    ld_go = 1;
    ld_byte(8'h12);
    ld_byte(8'h34);
    @(negedge clk_sys);
    reset_n = 0;
    #1;
    check("rst_mid_rgb", rgb(), 32'h0);
    check("rst_mid_sync", syn(), 32'h0);
    check("rst_mid_done", {31'h0, ld_done}, 32'h0);
    @(negedge clk_sys);
    reset_n = 1; ld_go = 0;
    show(4'd0);
    check("rst_e0", rgb(), 32'h5E5E5E);
    show(4'd5);
    check("rst_e5", rgb(), 32'hABFF4A);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
